pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage MIPS-style pipeline. It sequences the PC, IF/ID and ID/EX pipeline registers through three actions:
- Load-use bubbles.
- Taken-branch flushes.
- Data-memory wait holds.

The hazard inputs come from the IF/ID and ID/EX register outputs and from the MEM stage. A registered FSM with a cycle counter drives the enable and flush controls of the pipeline registers.

Parameters:
LOAD_STALLS, 1, bubbles inserted per load-use hazard (1..15)
FLUSH_CYCLES, 2, consecutive flush cycles per taken branch (1..15)
CNT_W, 4, width of internal down-counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
idex_memread  in  1  instruction in ID/EX is a load (M-control read bit)
idex_rt  in  5  load destination register held in ID/EX
ifid_rs  in  5  rs field of instruction in IF/ID
ifid_rt  in  5  rt field of instruction in IF/ID
ifid_uses_rt  in  1  IF/ID instruction reads rt
branch_taken  in  1  branch resolved taken in EX/MEM
dmem_req  in  1  MEM stage performing data access
dmem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID clear to NOP
idex_flush  out  1  ID/EX clear of WB/M/EX control fields (bubble)
pipe_hold  out  1  freeze ID/EX, EX/MEM, MEM/WB
state  out  2  current FSM state (debug)
stall_count, flush_count, wait_count  out  32 each  perf counters (see Optional Feature)

Behaviour:
- Reset is asynchronous, active-high; clock is clock.
- Outputs are combinational from the registered state, counter and current inputs. State, counter and ret_state update on rising clock.
- FSM states: RUN=0, LU_STALL=1, BR_FLUSH=2, MEM_WAIT=3.
- Default output set (RUN, no event): pc_write=1, ifid_write=1, ifid_flush=0, idex_flush=0, pipe_hold=0.
- hazard = idex_memread && idex_rt!=0 && (idex_rt==ifid_rs || (ifid_uses_rt && idex_rt==ifid_rt)).
- wait = dmem_req && !dmem_ready.
- RUN priority is wait > branch_taken > hazard.
  - wait: pc_write=0, ifid_write=0, pipe_hold=1; ret_state<=RUN; go MEM_WAIT.
  - branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1. If FLUSH_CYCLES>1, cnt<=FLUSH_CYCLES-1 and go BR_FLUSH; else stay RUN.
  - hazard: pc_write=0, ifid_write=0, idex_flush=1. If LOAD_STALLS>1, cnt<=LOAD_STALLS-1 and go LU_STALL; else stay RUN.
- LU_STALL:
  - Outputs: pc_write=0, ifid_write=0, idex_flush=1.
  - cnt decrements each cycle; when cnt==1, go RUN.
  - wait takes precedence: hold outputs, cnt frozen, ret_state<=LU_STALL, go MEM_WAIT.
- BR_FLUSH:
  - Outputs: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1.
  - branch_taken and hazard are ignored (wrong path).
  - cnt decrements; when cnt==1, go RUN.
  - wait takes precedence as in LU_STALL, with ret_state<=BR_FLUSH.
- MEM_WAIT:
  - Outputs: pc_write=0, ifid_write=0, pipe_hold=1, flushes=0; cnt frozen.
  - On dmem_ready, the current cycle still asserts hold; next state<=ret_state.
  - branch_taken and hazard are ignored while waiting.
- Simultaneous branch_taken and hazard in RUN: branch wins; the hazard is discarded because the IF/ID instruction is flushed.
- While reset is high:
  - pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, pipe_hold=0.
  - state=RUN, cnt=0, ret_state=RUN, perf counters=0.
- Reset asserted mid-stall or mid-wait aborts immediately; the first cycle after deassertion is a clean RUN.

Optional Feature:
HAZARD_PERF_EN.
- Defined: three 32-bit saturating counters (saturate at 0xFFFFFFFF), each incremented on every clock where the condition holds:
  - stall_count: a load-use bubble is issued (RUN hazard cycle or any LU_STALL cycle).
  - flush_count: ifid_flush=1 outside reset.
  - wait_count: pipe_hold=1.
- Undefined: the ports exist and are tied to 0; no counter logic is present.

Test Plan:
- LOAD_STALLS=1; idex_memread=1, idex_rt=8, ifid_rs=8 for one cycle -> that cycle pc_write=0, ifid_write=0, idex_flush=1; next cycle (memread=0) default outputs.
- Same stimulus with idex_rt=0, or ifid_uses_rt=0 and only rt matching -> no stall, default outputs.
- FLUSH_CYCLES=2; branch_taken pulse 1 cycle -> ifid_flush=idex_flush=1 for exactly 2 cycles, pc_write=1 throughout, state 0->2->0.
- dmem_req=1, dmem_ready low 3 cycles then high -> pipe_hold=1 and pc_write=0 for 4 cycles, then RUN.
- LOAD_STALLS=3; hazard, then wait of 2 cycles in first LU_STALL cycle -> 3 bubbles total, separated by 3 hold cycles; HAZARD_PERF_EN: stall_count=3, wait_count=3.
- Reset asserted in BR_FLUSH -> immediate flush/hold pattern of reset, state=0; after release branch_taken=0 gives default outputs.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use bubbles, taken-branch flushes, data-memory holds.
// Define HAZARD_PERF_EN to build the saturating stall/flush/wait performance counters.
module pipe_hazard_ctrl #(
    parameter int LOAD_STALLS  = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rt,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        ifid_uses_rt,
    input  logic        branch_taken,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        pipe_hold,
    output logic [1:0]  state,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count,
    output logic [31:0] wait_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        BR_FLUSH = 2'd2,
        MEM_WAIT = 2'd3
    } state_e;

    state_e           state_q, state_d;
    state_e           ret_q, ret_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic hazard;
    logic mem_wait;
    logic pc_write_c;
    logic ifid_write_c;
    logic ifid_flush_c;
    logic idex_flush_c;
    logic hold_c;
    logic bubble_c;

    always_comb begin
        hazard   = idex_memread && (idex_rt != 5'd0) &&
                   ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
        mem_wait = dmem_req && !dmem_ready;
    end

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        cnt_d        = cnt_q;
        pc_write_c   = 1'b1;
        ifid_write_c = 1'b1;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;
        hold_c       = 1'b0;
        bubble_c     = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_wait) begin
                    pc_write_c   = 1'b0;
                    ifid_write_c = 1'b0;
                    hold_c       = 1'b1;
                    ret_d        = RUN;
                    state_d      = MEM_WAIT;
                end else if (branch_taken) begin
                    // A simultaneous hazard is dropped: its IF/ID instruction is being flushed.
                    ifid_flush_c = 1'b1;
                    idex_flush_c = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                        state_d = BR_FLUSH;
                    end
                end else if (hazard) begin
                    pc_write_c   = 1'b0;
                    ifid_write_c = 1'b0;
                    idex_flush_c = 1'b1;
                    bubble_c     = 1'b1;
                    if (LOAD_STALLS > 1) begin
                        cnt_d   = CNT_W'(LOAD_STALLS - 1);
                        state_d = LU_STALL;
                    end
                end
            end

            LU_STALL: begin
                pc_write_c   = 1'b0;
                ifid_write_c = 1'b0;
                if (mem_wait) begin
                    hold_c  = 1'b1;
                    ret_d   = LU_STALL;
                    state_d = MEM_WAIT;
                end else begin
                    idex_flush_c = 1'b1;
                    bubble_c     = 1'b1;
                    cnt_d        = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = RUN;
                    end
                end
            end

            BR_FLUSH: begin
                if (mem_wait) begin
                    pc_write_c   = 1'b0;
                    ifid_write_c = 1'b0;
                    hold_c       = 1'b1;
                    ret_d        = BR_FLUSH;
                    state_d      = MEM_WAIT;
                end else begin
                    ifid_flush_c = 1'b1;
                    idex_flush_c = 1'b1;
                    cnt_d        = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = RUN;
                    end
                end
            end

            MEM_WAIT: begin
                pc_write_c   = 1'b0;
                ifid_write_c = 1'b0;
                hold_c       = 1'b1;
                // The completing cycle still holds; a withdrawn request releases as well.
                if (!mem_wait) begin
                    state_d = ret_q;
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase

        if (reset) begin
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
            hold_c       = 1'b0;
            bubble_c     = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            ret_q   <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_write   = pc_write_c;
    assign ifid_write = ifid_write_c;
    assign ifid_flush = ifid_flush_c;
    assign idex_flush = idex_flush_c;
    assign pipe_hold  = hold_c;
    assign state      = state_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;
    logic [31:0] wait_cnt_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            if (bubble_c) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
            if (ifid_flush_c) begin
                flush_cnt_q <= sat_inc(flush_cnt_q);
            end
            if (hold_c) begin
                wait_cnt_q <= sat_inc(wait_cnt_q);
            end
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
    assign wait_count  = wait_cnt_q;
`else
    assign stall_count = 32'd0;
    assign flush_count = 32'd0;
    assign wait_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: one instance with LOAD_STALLS=1, one with LOAD_STALLS=3.
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Control vectors {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold}
    localparam logic [4:0] DEF = 5'b11000;
    localparam logic [4:0] BUB = 5'b00010;
    localparam logic [4:0] FLS = 5'b11110;
    localparam logic [4:0] HLD = 5'b00001;
    localparam logic [4:0] RST = 5'b00110;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       idex_memread = 1'b0;
    logic [4:0] idex_rt = 5'd0;
    logic [4:0] ifid_rs = 5'd0;
    logic [4:0] ifid_rt = 5'd0;
    logic       ifid_uses_rt = 1'b0;
    logic       branch_taken = 1'b0;
    logic       dmem_req = 1'b0;
    logic       dmem_ready = 1'b0;

    logic        a_pc, a_ifw, a_iff, a_idf, a_hold;
    logic [1:0]  a_state;
    logic [31:0] a_stall, a_flush, a_wait;
    logic        b_pc, b_ifw, b_iff, b_idf, b_hold;
    logic [1:0]  b_state;
    logic [31:0] b_stall, b_flush, b_wait;

    pipe_hazard_ctrl #(.LOAD_STALLS(1), .FLUSH_CYCLES(2), .CNT_W(4)) u_a (
        .clock(clock), .reset(reset), .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(a_pc), .ifid_write(a_ifw), .ifid_flush(a_iff), .idex_flush(a_idf),
        .pipe_hold(a_hold), .state(a_state),
        .stall_count(a_stall), .flush_count(a_flush), .wait_count(a_wait)
    );

    pipe_hazard_ctrl #(.LOAD_STALLS(3), .FLUSH_CYCLES(2), .CNT_W(4)) u_b (
        .clock(clock), .reset(reset), .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(b_pc), .ifid_write(b_ifw), .ifid_flush(b_iff), .idex_flush(b_idf),
        .pipe_hold(b_hold), .state(b_state),
        .stall_count(b_stall), .flush_count(b_flush), .wait_count(b_wait)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      tag;
        logic       sel;
        logic [6:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  total = 0;
    int  bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic rst, input logic mr, input logic [4:0] rt,
                         input logic [4:0] rs, input logic [4:0] irt, input logic uses,
                         input logic br, input logic req, input logic rdy);
        @(negedge clock);
        reset        = rst;
        idex_memread = mr;
        idex_rt      = rt;
        ifid_rs      = rs;
        ifid_rt      = irt;
        ifid_uses_rt = uses;
        branch_taken = br;
        dmem_req     = req;
        dmem_ready   = rdy;
    endtask

    task automatic expect_out(input string tag, input logic sel, input logic [1:0] st,
                              input logic [4:0] ctl);
        sb_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = {st, ctl};
        sb_q.push_back(e);
    endtask

    task automatic check_perf(input string tag, input logic sel, input int s, input int f,
                              input int w);
        #3;
        check_val({tag, "_stall"}, sel ? b_stall : a_stall, PERF ? 32'(s) : 32'd0);
        check_val({tag, "_flush"}, sel ? b_flush : a_flush, PERF ? 32'(f) : 32'd0);
        check_val({tag, "_wait"},  sel ? b_wait  : a_wait,  PERF ? 32'(w) : 32'd0);
    endtask

    // Monitor: outputs are settled 2 time units after the driving edge.
    initial begin
        forever begin
            @(negedge clock);
            #2;
            while (sb_q.size() > 0) begin
                sb_t        e;
                logic [6:0] obs;
                e   = sb_q.pop_front();
                obs = e.sel ? {b_state, b_pc, b_ifw, b_iff, b_idf, b_hold}
                            : {a_state, a_pc, a_ifw, a_iff, a_idf, a_hold};
                check_val(e.tag, 32'(obs), 32'(e.exp));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("rst_a", 0, 2'd0, RST);
        expect_out("rst_b", 1, 2'd0, RST);
        check_perf("rst_perf_a", 0, 0, 0, 0);
        check_perf("rst_perf_b", 1, 0, 0, 0);

        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("idle_a", 0, 2'd0, DEF);
        expect_out("idle_b", 1, 2'd0, DEF);

        // Load-use on rs
        apply(0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0); expect_out("lu_rs", 0, 2'd0, BUB);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);          expect_out("lu_rs_after", 0, 2'd0, DEF);
        // No-hazard cases, then rt-only match with rt used
        apply(0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0); expect_out("lu_r0", 0, 2'd0, DEF);
        apply(0, 1, 5'd9, 5'd3, 5'd9, 0, 0, 0, 0); expect_out("lu_rt_unused", 0, 2'd0, DEF);
        apply(0, 1, 5'd9, 5'd3, 5'd9, 1, 0, 0, 0); expect_out("lu_rt_used", 0, 2'd0, BUB);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);          expect_out("lu_rt_after", 0, 2'd0, DEF);

        // Branch flush, two cycles
        apply(0, 0, 0, 0, 0, 0, 1, 0, 0);          expect_out("br_c0", 0, 2'd0, FLS);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);          expect_out("br_c1", 0, 2'd2, FLS);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);          expect_out("br_done", 0, 2'd0, DEF);
        // Branch together with hazard: branch wins, hazard ignored while flushing
        apply(0, 1, 5'd8, 5'd8, 5'd0, 0, 1, 0, 0); expect_out("brhz_c0", 0, 2'd0, FLS);
        apply(0, 1, 5'd8, 5'd8, 5'd0, 0, 1, 0, 0); expect_out("brhz_c1", 0, 2'd2, FLS);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);          expect_out("brhz_done", 0, 2'd0, DEF);

        // Memory wait: three not-ready cycles then ready
        apply(0, 0, 0, 0, 0, 0, 0, 1, 0);          expect_out("mw_c0", 0, 2'd0, HLD);
        apply(0, 0, 0, 0, 0, 0, 0, 1, 0);          expect_out("mw_c1", 0, 2'd3, HLD);
        apply(0, 0, 0, 0, 0, 0, 0, 1, 0);          expect_out("mw_c2", 0, 2'd3, HLD);
        apply(0, 0, 0, 0, 0, 0, 0, 1, 1);          expect_out("mw_rdy", 0, 2'd3, HLD);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);          expect_out("mw_done", 0, 2'd0, DEF);
        check_perf("perf_a", 0, 2, 4, 4);

        // Reset during branch flush
        apply(0, 0, 0, 0, 0, 0, 1, 0, 0);          expect_out("rbr_c0", 0, 2'd0, FLS);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("rbr_rst_a", 0, 2'd0, RST);
        expect_out("rbr_rst_b", 1, 2'd0, RST);
        check_perf("rbr_perf_a", 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("rbr_after_a", 0, 2'd0, DEF);
        expect_out("rbr_after_b", 1, 2'd0, DEF);

        // LOAD_STALLS=3 with a memory wait inside the first stall cycle
        apply(0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0); expect_out("ls3_b0", 1, 2'd0, BUB);
        apply(0, 0, 0, 0, 0, 0, 0, 1, 0);          expect_out("ls3_h0", 1, 2'd1, HLD);
        apply(0, 0, 0, 0, 0, 0, 0, 1, 0);          expect_out("ls3_h1", 1, 2'd3, HLD);
        apply(0, 0, 0, 0, 0, 0, 0, 1, 1);          expect_out("ls3_h2", 1, 2'd3, HLD);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);          expect_out("ls3_b1", 1, 2'd1, BUB);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);          expect_out("ls3_b2", 1, 2'd1, BUB);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);          expect_out("ls3_done", 1, 2'd0, DEF);
        check_perf("perf_b", 1, 3, 0, 3);

        repeat (3) @(negedge clock);
        #3;
        check_val("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
